// File: rtl/rtl_bigreg_writer_if.sv
// Mem-map RTL write port: one (id, data) beat per valid/ready handshake.
// The writer drives the master side; the mem map drives the slave side.
interface rtl_bigreg_writer_if #(
  parameter int ID_W          = 8,
  parameter int WD_DATA_WIDTH = 16
);
  logic                     wr_valid;
  logic                     wr_ready;
  logic [ID_W-1:0]          wr_id;
  logic [WD_DATA_WIDTH-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_id,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_id,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/rtl_bigreg_writer.sv
// Publishes a wide RTL value into the mem map as framed chunk writes:
// invalidate, chunks (LSB first), then validate, so the PS never sees a torn value.
module rtl_bigreg_writer #(
  parameter int DATA_WIDTH    = 32,
  parameter int WD_DATA_WIDTH = 16,
  parameter int MEM_SIZE      = 256,
  parameter int BASE_ID       = 29
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  rtl_bigreg_writer_if.master   wr,
  output logic                  busy,
  output logic [7:0]            drop_cnt
);

  localparam int ID_W    = $clog2(MEM_SIZE);
  localparam int SAMPLES = DATA_WIDTH / WD_DATA_WIDTH;
  localparam int IDX_W   = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;

  localparam logic [ID_W-1:0]  VALID_ID = ID_W'(BASE_ID + SAMPLES);
  localparam logic [ID_W-1:0]  BASE     = ID_W'(BASE_ID);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_INVAL,
    S_CHUNK,
    S_VALID
  } state_t;

  state_t                   state, state_n;
  logic [IDX_W-1:0]         idx, idx_n;
  logic [DATA_WIDTH-1:0]    shadow, shadow_n;
  logic [DATA_WIDTH-1:0]    pend, pend_n;
  logic                     pend_full, pend_full_n;
  logic [7:0]               drop_n;
  logic                     beat;
  logic                     wr_valid_n;
  logic [ID_W-1:0]          wr_id_n;
  logic [WD_DATA_WIDTH-1:0] wr_data_n;
  logic [WD_DATA_WIDTH-1:0] chunk_n;

  assign beat = wr.wr_valid & wr.wr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      shadow     <= '0;
      pend       <= '0;
      pend_full  <= 1'b0;
      drop_cnt   <= '0;
      busy       <= 1'b0;
      wr.wr_valid <= 1'b0;
      wr.wr_id   <= '0;
      wr.wr_data <= '0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      shadow     <= shadow_n;
      pend       <= pend_n;
      pend_full  <= pend_full_n;
      drop_cnt   <= drop_n;
      busy       <= wr_valid_n;
      wr.wr_valid <= wr_valid_n;
      wr.wr_id   <= wr_id_n;
      wr.wr_data <= wr_data_n;
    end
  end

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    shadow_n    = shadow;
    pend_n      = pend;
    pend_full_n = pend_full;
    drop_n      = drop_cnt;
    wr_valid_n  = 1'b0;
    wr_id_n     = '0;
    wr_data_n   = '0;
    chunk_n     = '0;

    unique case (state)
      S_IDLE: begin
        if (data_in_valid) begin
          shadow_n = data_in;
          state_n  = S_INVAL;
        end
      end
      S_INVAL: begin
        if (beat) begin
          state_n = S_CHUNK;
          idx_n   = '0;
        end
      end
      S_CHUNK: begin
        if (beat) begin
          if (idx == LAST_IDX) state_n = S_VALID;
          else idx_n = idx + IDX_W'(1);
        end
      end
      S_VALID: begin
        if (beat) begin
          // A same-cycle offer is newer than anything pending
          if (data_in_valid || pend_full) begin
            shadow_n    = data_in_valid ? data_in : pend;
            pend_full_n = 1'b0;
            state_n     = S_INVAL;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (state != S_IDLE && data_in_valid) begin
      if (!(state == S_VALID && beat)) begin
        pend_n      = data_in;
        pend_full_n = 1'b1;
      end
      if (pend_full && drop_cnt != 8'hFF) drop_n = drop_cnt + 8'd1;
    end

    for (int i = 0; i < SAMPLES; i++) begin
      if (idx_n == IDX_W'(i))
        chunk_n = shadow_n[i*WD_DATA_WIDTH +: WD_DATA_WIDTH];
    end

    wr_valid_n = (state_n != S_IDLE);
    unique case (state_n)
      S_INVAL: wr_id_n = VALID_ID;
      S_CHUNK: begin
        wr_id_n   = BASE + ID_W'(idx_n);
        wr_data_n = chunk_n;
      end
      S_VALID: begin
        wr_id_n   = VALID_ID;
        wr_data_n = WD_DATA_WIDTH'(1);
      end
      default: begin
        wr_id_n   = '0;
        wr_data_n = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_rtl_bigreg_writer.sv
// Bench for rtl_bigreg_writer: directed scenarios plus random traffic
// checked against a frame-queue model of published mem-map writes.
module tb_rtl_bigreg_writer;

  localparam int VID = 31;
  localparam int BID = 29;
  localparam int NS  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_in = '0;
  logic        data_in_valid = 1'b0;
  logic        busy;
  logic [7:0]  drop_cnt;

  rtl_bigreg_writer_if #(.ID_W(8), .WD_DATA_WIDTH(16)) wr_if ();

  always #5 clk = ~clk;

  rtl_bigreg_writer #(
    .DATA_WIDTH(32),
    .WD_DATA_WIDTH(16),
    .MEM_SIZE(256),
    .BASE_ID(29)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .data_in_valid(data_in_valid),
    .wr(wr_if),
    .busy(busy),
    .drop_cnt(drop_cnt)
  );

  typedef struct {
    int id;
    int data;
    bit last;
  } beat_t;

  beat_t       q[$];
  logic [31:0] pend;
  bit          pend_full;
  int          drops;
  int          ncmp;
  int          nfail;
  int          oid[$];
  int          odat[$];

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    ncmp++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, o, e);
    end
  endtask

  function automatic void push_frame(input logic [31:0] v);
    q.push_back('{id: VID, data: 0, last: 1'b0});
    for (int i = 0; i < NS; i++)
      q.push_back('{id: BID + i, data: int'((v >> (16 * i)) & 32'hFFFF),
                    last: 1'b0});
    q.push_back('{id: VID, data: 1, last: 1'b1});
  endfunction

  function automatic void model_reset();
    q.delete();
    pend_full = 1'b0;
    pend      = '0;
    drops     = 0;
  endfunction

  task automatic step(input bit rdy, input bit off, input logic [31:0] v);
    bit    was_busy;
    beat_t b;
    @(negedge clk);
    wr_if.wr_ready = rdy;
    data_in_valid  = off;
    data_in        = v;
    chk("wr_valid", {31'b0, wr_if.wr_valid}, {31'b0, q.size() != 0});
    chk("busy", {31'b0, busy}, {31'b0, q.size() != 0});
    chk("drop_cnt", {24'b0, drop_cnt}, drops);
    if (q.size() != 0) begin
      chk("wr_id", {24'b0, wr_if.wr_id}, q[0].id);
      chk("wr_data", {16'b0, wr_if.wr_data}, q[0].data);
    end
    if (wr_if.wr_valid && rdy) begin
      oid.push_back(int'(wr_if.wr_id));
      odat.push_back(int'(wr_if.wr_data));
    end
    was_busy = (q.size() != 0);
    if (off) begin
      if (was_busy) begin
        if (pend_full && drops < 255) drops++;
        pend      = v;
        pend_full = 1'b1;
      end else begin
        push_frame(v);
      end
    end
    if (was_busy && rdy) begin
      b = q.pop_front();
      if (b.last && pend_full) begin
        push_frame(pend);
        pend_full = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0);
  endtask

  int eid[4];
  int edat[4];

  initial begin
    ncmp  = 0;
    nfail = 0;
    model_reset();
    wr_if.wr_ready = 1'b1;

    // reset state
    #2;
    chk("rst_valid", {31'b0, wr_if.wr_valid}, 0);
    chk("rst_id", {24'b0, wr_if.wr_id}, 0);
    chk("rst_data", {16'b0, wr_if.wr_data}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_drop", {24'b0, drop_cnt}, 0);
    #1 rst = 1'b0;

    // 1: basic publish
    oid.delete(); odat.delete();
    step(1, 1, 32'hDEADBEEF);
    idle(5);
    eid  = '{31, 29, 30, 31};
    edat = '{0, 'hBEEF, 'hDEAD, 1};
    chk("t1_nbeats", oid.size(), 4);
    for (int i = 0; i < 4 && i < oid.size(); i++) begin
      chk("t1_id", oid[i], eid[i]);
      chk("t1_data", odat[i], edat[i]);
    end

    // 2: back-pressure on chunk 0
    step(1, 1, 32'hDEADBEEF);
    step(1, 0, '0);
    step(0, 0, '0);
    step(0, 0, '0);
    step(0, 0, '0);
    step(1, 0, '0);
    step(1, 0, '0);
    step(1, 0, '0);
    idle(2);

    // 3: overwrite while busy, back-to-back publish
    oid.delete(); odat.delete();
    step(1, 1, 32'h11111111);
    step(1, 1, 32'h22222222);
    step(1, 1, 32'h33333333);
    idle(12);
    chk("t3_nbeats", oid.size(), 8);
    if (oid.size() >= 8) begin
      chk("t3_first", odat[1], 'h1111);
      chk("t3_second", odat[6], 'h3333);
    end
    chk("t3_drop", {24'b0, drop_cnt}, 1);

    // 4: offer on the validate beat
    oid.delete(); odat.delete();
    step(1, 1, 32'hAAAA5555);
    idle(3);
    step(1, 1, 32'h1234CAFE);
    idle(6);
    chk("t4_nbeats", oid.size(), 8);
    if (oid.size() >= 8) begin
      chk("t4_inval", oid[4], 31);
      chk("t4_lo", odat[5], 'hCAFE);
      chk("t4_hi", odat[6], 'h1234);
    end

    // 6: saturating drop counter
    for (int i = 0; i < 300; i++) step(0, 1, $urandom);
    step(0, 0, '0);
    chk("t6_sat", {24'b0, drop_cnt}, 255);
    idle(12);

    // 5: reset during the chunk-1 beat
    step(1, 1, 32'h0BADF00D);
    step(1, 0, '0);
    step(1, 0, '0);
    step(1, 0, '0);
    #1 rst = 1'b1;
    #1;
    chk("t5_valid", {31'b0, wr_if.wr_valid}, 0);
    chk("t5_busy", {31'b0, busy}, 0);
    chk("t5_drop", {24'b0, drop_cnt}, 0);
    model_reset();
    #1 rst = 1'b0;
    oid.delete(); odat.delete();
    step(1, 1, 32'h5A5AC3C3);
    idle(6);
    chk("t5_nbeats", oid.size(), 4);
    if (oid.size() >= 4) chk("t5_lo", odat[1], 'hC3C3);

    // random traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2, $urandom);
    idle(20);
    chk("end_idle", {31'b0, wr_if.wr_valid}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
